// File: rtl/pad_scan_ctrl.sv
// Zero-padding scan sequencer: walks an IMG_W x IMG_H map plus a PAD-pixel border in raster
// order, issuing one (row, col, pad_sel, mem_addr) beat per valid/ready handshake.
module pad_scan_ctrl #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned PAD    = 1,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pad_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CNT_W-1:0]  row,
  output logic [CNT_W-1:0]  col
);

  localparam int unsigned PW = IMG_W + 2 * PAD;
  localparam int unsigned PH = IMG_H + 2 * PAD;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PW - 1);
  localparam logic [CNT_W-1:0] LAST_R = CNT_W'(PH - 1);

  // Signed bounds keep the border test well-formed when PAD is zero.
  localparam int PAD_I   = int'(PAD);
  localparam int ROW_END = int'(PAD + IMG_H);
  localparam int COL_END = int'(PAD + IMG_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;

  logic              accept;
  logic              last_beat;
  logic [CNT_W-1:0]  nxt_row;
  logic [CNT_W-1:0]  nxt_col;
  logic [ADDR_W-1:0] nxt_cnt;
  logic              nxt_pad;

  function automatic logic is_border(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] c);
    int ri;
    int ci;
    ri = int'(r);
    ci = int'(c);
    return (ri < PAD_I) || (ri >= ROW_END) || (ci < PAD_I) || (ci >= COL_END);
  endfunction

  // Next coordinate and running interior address for the beat after an acceptance.
  always_comb begin
    accept    = out_valid & out_ready;
    last_beat = (row == LAST_R) && (col == LAST_C);
    nxt_col   = col + CNT_W'(1);
    nxt_row   = row;
    if (col == LAST_C) begin
      nxt_col = '0;
      nxt_row = row + CNT_W'(1);
    end
    nxt_cnt = pad_sel ? addr_cnt : addr_cnt + ADDR_W'(1);
    nxt_pad = is_border(nxt_row, nxt_col);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      pad_sel   <= 1'b0;
      mem_addr  <= '0;
      row       <= '0;
      col       <= '0;
      addr_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            row       <= '0;
            col       <= '0;
            pad_sel   <= is_border(CNT_W'(0), CNT_W'(0));
            mem_addr  <= '0;
            addr_cnt  <= '0;
          end
        end
        SCAN: begin
          if (accept) begin
            if (last_beat) begin
              state     <= DONE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              pad_sel   <= 1'b0;
              mem_addr  <= '0;
              row       <= '0;
              col       <= '0;
            end else begin
              row      <= nxt_row;
              col      <= nxt_col;
              pad_sel  <= nxt_pad;
              addr_cnt <= nxt_cnt;
              mem_addr <= nxt_pad ? '0 : nxt_cnt;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_scan_ctrl.sv
// Bench for pad_scan_ctrl: three configurations checked against a coordinate-arithmetic model,
// plus spot vectors, stall patterns, start-in-SCAN/DONE and mid-scan reset sequences.
module tb_pad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [3];
  logic       ready_s [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       valid_s [3];
  logic       pad_s   [3];
  logic [11:0] addr_s [3];
  logic [7:0]  row_s  [3];
  logic [7:0]  col_s  [3];

  int cw[3] = '{4, 3, 1};
  int ch[3] = '{4, 2, 1};
  int cp[3] = '{1, 0, 2};

  int cap_r [3][64];
  int cap_c [3][64];
  int cap_p [3][64];
  int cap_a [3][64];
  int cap_n [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d;
    int k;
    int r;
    int c;
    int p;
    int a;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  pad_scan_ctrl #(.IMG_W(4), .IMG_H(4), .PAD(1), .ADDR_W(12), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .out_valid(valid_s[0]), .out_ready(ready_s[0]), .pad_sel(pad_s[0]),
    .mem_addr(addr_s[0]), .row(row_s[0]), .col(col_s[0]));

  pad_scan_ctrl #(.IMG_W(3), .IMG_H(2), .PAD(0), .ADDR_W(12), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .out_valid(valid_s[1]), .out_ready(ready_s[1]), .pad_sel(pad_s[1]),
    .mem_addr(addr_s[1]), .row(row_s[1]), .col(col_s[1]));

  pad_scan_ctrl #(.IMG_W(1), .IMG_H(1), .PAD(2), .ADDR_W(12), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .out_valid(valid_s[2]), .out_ready(ready_s[2]), .pad_sel(pad_s[2]),
    .mem_addr(addr_s[2]), .row(row_s[2]), .col(col_s[2]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Beat k of a padded raster scan: coordinate by division, address from the unpadded pixel.
  function automatic void model(input int d, input int k,
                                output int r, output int c, output int p, output int a);
    int pw;
    pw = cw[d] + 2 * cp[d];
    r  = k / pw;
    c  = k % pw;
    p  = (r < cp[d] || r >= cp[d] + ch[d] || c < cp[d] || c >= cp[d] + cw[d]) ? 1 : 0;
    a  = (p == 1) ? 0 : (r - cp[d]) * cw[d] + (c - cp[d]);
  endfunction

  // Starts a scan on DUT d from a negedge in IDLE; mode 0 ready=1, 1 pattern 1,0,0, 2 random.
  task automatic run_scan(input int d, input int mode, input bit poke);
    int n, k, cyc, r, c, p, a;
    logic rdy;
    n   = (cw[d] + 2 * cp[d]) * (ch[d] + 2 * cp[d]);
    k   = 0;
    cyc = 0;
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    while (k < n && cyc < 1000) begin
      model(d, k, r, c, p, a);
      chk($sformatf("d%0d b%0d valid", d, k), int'(valid_s[d]), 1);
      chk($sformatf("d%0d b%0d busy", d, k), int'(busy_s[d]), 1);
      chk($sformatf("d%0d b%0d done_early", d, k), int'(done_s[d]), 0);
      chk($sformatf("d%0d b%0d row", d, k), int'(row_s[d]), r);
      chk($sformatf("d%0d b%0d col", d, k), int'(col_s[d]), c);
      chk($sformatf("d%0d b%0d pad_sel", d, k), int'(pad_s[d]), p);
      chk($sformatf("d%0d b%0d mem_addr", d, k), int'(addr_s[d]), a);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (poke) start_s[d] = 1'($urandom_range(0, 1));
      ready_s[d] = rdy;
      if (rdy) begin
        cap_r[d][k] = int'(row_s[d]);
        cap_c[d][k] = int'(col_s[d]);
        cap_p[d][k] = int'(pad_s[d]);
        cap_a[d][k] = int'(addr_s[d]);
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    cap_n[d] = k;
    chk($sformatf("d%0d beat_count", d), k, n);
    start_s[d] = poke;
    chk($sformatf("d%0d done_pulse", d), int'(done_s[d]), 1);
    chk($sformatf("d%0d valid_after_last", d), int'(valid_s[d]), 0);
    chk($sformatf("d%0d busy_after_last", d), int'(busy_s[d]), 0);
    @(negedge clk);
    start_s[d] = 1'b0;
    ready_s[d] = 1'b0;
    chk($sformatf("d%0d done_clear", d), int'(done_s[d]), 0);
    chk($sformatf("d%0d idle_no_restart", d), int'(valid_s[d]), 0);
    chk($sformatf("d%0d idle_busy", d), int'(busy_s[d]), 0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 6, 1, 0, 1, 0};
    tbl[2]  = '{0, 7, 1, 1, 0, 0};
    tbl[3]  = '{0, 8, 1, 2, 0, 1};
    tbl[4]  = '{0, 28, 4, 4, 0, 15};
    tbl[5]  = '{0, 29, 4, 5, 1, 0};
    tbl[6]  = '{0, 35, 5, 5, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 3, 1, 0, 0, 3};
    tbl[9]  = '{1, 5, 1, 2, 0, 5};
    tbl[10] = '{2, 11, 2, 1, 1, 0};
    tbl[11] = '{2, 12, 2, 2, 0, 0};
    tbl[12] = '{2, 24, 4, 4, 1, 0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d reset busy", i), int'(busy_s[i]), 0);
      chk($sformatf("d%0d reset done", i), int'(done_s[i]), 0);
      chk($sformatf("d%0d reset valid", i), int'(valid_s[i]), 0);
      chk($sformatf("d%0d reset pad_sel", i), int'(pad_s[i]), 0);
      chk($sformatf("d%0d reset mem_addr", i), int'(addr_s[i]), 0);
      chk($sformatf("d%0d reset row", i), int'(row_s[i]), 0);
      chk($sformatf("d%0d reset col", i), int'(col_s[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Full-throughput scans on all three geometries, then spot vectors from the captures.
    run_scan(0, 0, 1'b0);
    run_scan(1, 0, 1'b0);
    run_scan(2, 0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d row", i), cap_r[tbl[i].d][tbl[i].k], tbl[i].r);
      chk($sformatf("vec%0d col", i), cap_c[tbl[i].d][tbl[i].k], tbl[i].c);
      chk($sformatf("vec%0d pad_sel", i), cap_p[tbl[i].d][tbl[i].k], tbl[i].p);
      chk($sformatf("vec%0d mem_addr", i), cap_a[tbl[i].d][tbl[i].k], tbl[i].a);
    end

    // Stall pattern, then start pulses during SCAN/DONE followed by an immediate restart.
    run_scan(0, 1, 1'b0);
    run_scan(0, 0, 1'b1);
    run_scan(0, 0, 1'b0);

    for (int d = 0; d < 3; d++)
      repeat (6) run_scan(d, 2, 1'b1);

    // Reset mid-scan at beat 10 of the 6x6 padded scan.
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    ready_s[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst row", int'(row_s[0]), 1);
    chk("pre_rst col", int'(col_s[0]), 4);
    chk("pre_rst mem_addr", int'(addr_s[0]), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst valid", int'(valid_s[0]), 0);
    chk("mid_rst busy", int'(busy_s[0]), 0);
    chk("mid_rst done", int'(done_s[0]), 0);
    chk("mid_rst pad_sel", int'(pad_s[0]), 0);
    chk("mid_rst mem_addr", int'(addr_s[0]), 0);
    chk("mid_rst row", int'(row_s[0]), 0);
    chk("mid_rst col", int'(col_s[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst done", int'(done_s[0]), 0);
      chk("post_rst valid", int'(valid_s[0]), 0);
    end
    ready_s[0] = 1'b0;
    run_scan(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
